payload_frame_ctrl: RTL
=======================

PAYLOAD_FRAME_CTRL -- requirements
Module: payload_frame_ctrl

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 1024: payload words per frame; legal range 2..65535.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: maximum idle gap between words inside a frame; used only under FRAME_TIMEOUT_EN.
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_sync_reset  input  1  one-cycle resync strobe from the packet decoder.
REQ-006 i_word_valid  input  1  one-cycle strobe: decoded payload word present.
REQ-007 i_word_data  input  32  decoded payload word, qualified by i_word_valid.
REQ-008 i_fifo_full  input  1  downstream FIFO full flag.
REQ-009 o_fifo_wr_en  output  1  FIFO write strobe.
REQ-010 o_fifo_wr_data  output  32  FIFO write data, qualified by o_fifo_wr_en.
REQ-011 o_frame_start  output  1  one-cycle pulse with the first write of a frame.
REQ-012 o_frame_done  output  1  one-cycle pulse with the last write of a frame.
REQ-013 o_frame_count  output  16  completed-frame counter; wraps 0xFFFF->0x0000.
REQ-014 o_overflow  output  1  sticky: a word was dropped because the FIFO was full.
REQ-015 o_timeout  output  1  sticky: inter-word gap exceeded TIMEOUT_CYCLES.
REQ-016 o_busy  output  1  high whenever state is not sIDLE.

Function
REQ-017 The FSM SHALL have states sIDLE, sFILL and sERR, with a 16-bit word counter.
REQ-018 All outputs SHALL be registered; a word accepted in cycle N SHALL appear on o_fifo_wr_en/o_fifo_wr_data in cycle N+1, using i_fifo_full sampled in cycle N.
REQ-019 A word is accepted when i_word_valid=1, i_fifo_full=0, the state is not sERR and i_sync_reset=0.
REQ-020 sIDLE, accepted word: write it, pulse o_frame_start, set the counter to 1, go to sFILL.
REQ-021 sFILL, accepted word: write it and increment the counter; when the counter reaches WORDS_PER_FRAME, pulse o_frame_done with that write, increment o_frame_count, clear the counter and go to sIDLE.
REQ-022 i_word_valid=1 with i_fifo_full=1 in sIDLE or sFILL: drop the word (no write), set o_overflow, go to sERR.
REQ-023 sERR: drop all words, perform no writes and hold the counter until i_sync_reset.
REQ-024 i_sync_reset=1 in any state: go to sIDLE, clear the counter, o_frame_count, o_overflow and o_timeout; any same-cycle word is dropped without setting o_overflow.
REQ-025 o_fifo_wr_data SHALL read 0x00000000 whenever o_fifo_wr_en=0.
REQ-026 Frames SHALL be written back to back: the word after o_frame_done starts a new frame with o_frame_start.

Reset
REQ-027 While i_reset_n=0: state=sIDLE, counter=0, and every output = 0 (including o_fifo_wr_data and o_frame_count), asynchronously.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no further writes; the first accepted word after release starts a new frame.

Configuration
REQ-029 Macro FRAME_TIMEOUT_EN defined: in sFILL a gap counter clears on each accepted word and increments otherwise; when it reaches TIMEOUT_CYCLES, set o_timeout and go to sERR.
REQ-030 FRAME_TIMEOUT_EN undefined: no gap counter is built, o_timeout is tied to 0 and sFILL waits indefinitely.

Verification (WORDS_PER_FRAME=4, TIMEOUT_CYCLES=8)
REQ-031 Send 4 words 0xA0..0xA3, FIFO not full -> 4 writes at one-cycle latency; frame_start with 0xA0, frame_done with 0xA3; o_frame_count=1; o_busy low afterwards.
REQ-032 Send 8 consecutive words -> 8 writes, two start/done pulse pairs, o_frame_count=2.
REQ-033 Send 2 words, then 1 word with i_fifo_full=1, then 3 more -> only 2 writes, o_overflow=1, sERR holds; after i_sync_reset, o_overflow=0 and the next word pulses o_frame_start.
REQ-034 Send i_sync_reset and i_word_valid in the same cycle -> no write, o_overflow stays 0, state sIDLE.
REQ-035 Send 2 words, then drive i_reset_n low for 1 cycle -> all outputs 0; the next 4 words form a complete frame.
REQ-036 With FRAME_TIMEOUT_EN, send 1 word then an idle gap of 8 cycles -> o_timeout=1 and later words are dropped; without the macro -> o_timeout stays 0 and the frame still completes.

Source files
------------

// File: rtl/payload_frame_ctrl.sv
// Groups decoded payload words into fixed-length frames written to a downstream FIFO.
// Optional inter-word gap watchdog enabled by defining FRAME_TIMEOUT_EN.
module payload_frame_ctrl #(
  parameter int unsigned WORDS_PER_FRAME = 1024,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_sync_reset,
  input  logic        i_word_valid,
  input  logic [31:0] i_word_data,
  input  logic        i_fifo_full,
  output logic        o_fifo_wr_en,
  output logic [31:0] o_fifo_wr_data,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic [15:0] o_frame_count,
  output logic        o_overflow,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {sIDLE, sFILL, sERR} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic                ovf_q, ovf_d;
  logic                tmo_q, tmo_d;
  logic                busy_q, busy_d;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GAP_W-1:0]    gap_inc_c;
  assign gap_inc_c = gap_q + GAP_W'(1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state and next-output logic; sync reset overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    fcnt_d    = fcnt_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
`ifdef FRAME_TIMEOUT_EN
    gap_d     = gap_q;
`endif
    if (i_sync_reset) begin
      state_d = sIDLE;
      cnt_d   = '0;
      fcnt_d  = '0;
      ovf_d   = 1'b0;
      tmo_d   = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      gap_d   = '0;
`endif
    end else begin
      case (state_q)
        sIDLE: begin
          if (i_word_valid && i_fifo_full) begin
            ovf_d   = 1'b1;
            state_d = sERR;
          end else if (i_word_valid) begin
            wr_en_d   = 1'b1;
            wr_data_d = i_word_data;
            start_d   = 1'b1;
            cnt_d     = CNT_W'(1);
            state_d   = sFILL;
`ifdef FRAME_TIMEOUT_EN
            gap_d     = '0;
`endif
          end
        end
        sFILL: begin
          if (i_word_valid && i_fifo_full) begin
            ovf_d   = 1'b1;
            state_d = sERR;
          end else if (i_word_valid) begin
            wr_en_d   = 1'b1;
            wr_data_d = i_word_data;
            cnt_d     = cnt_inc_c;
`ifdef FRAME_TIMEOUT_EN
            gap_d     = '0;
`endif
            if (cnt_inc_c == CNT_W'(WORDS_PER_FRAME)) begin
              done_d  = 1'b1;
              fcnt_d  = fcnt_q + CNT_W'(1);
              cnt_d   = '0;
              state_d = sIDLE;
            end
          end
`ifdef FRAME_TIMEOUT_EN
          else begin
            gap_d = gap_inc_c;
            if (gap_inc_c == GAP_W'(TIMEOUT_CYCLES)) begin
              tmo_d   = 1'b1;
              state_d = sERR;
            end
          end
`endif
        end
        sERR:    state_d = sERR;
        default: state_d = sIDLE;
      endcase
    end
    busy_d = (state_d != sIDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= sIDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      fcnt_q    <= '0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      done_q    <= done_d;
      fcnt_q    <= fcnt_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
`ifdef FRAME_TIMEOUT_EN
      gap_q     <= gap_d;
`endif
    end
  end

  assign o_fifo_wr_en   = wr_en_q;
  assign o_fifo_wr_data = wr_data_q;
  assign o_frame_start  = start_q;
  assign o_frame_done   = done_q;
  assign o_frame_count  = fcnt_q;
  assign o_overflow     = ovf_q;
  assign o_timeout      = tmo_q;
  assign o_busy         = busy_q;

endmodule
